// File: rtl/word_block_packer.sv
// Gathers four words through an upstream 4:1 selector into one block; valid 4 edges after start.
// The block is held with block_valid until block_ready; start during hold is ignored unless ready.
module word_block_packer #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [1:0]          mux_select,
  input  logic [WORD_W-1:0]   mux_result,
  output logic [4*WORD_W-1:0] block_out,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                busy,
  output logic [15:0]         block_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               mux_select_q, mux_select_d;
  logic [2:0][WORD_W-1:0]   stage_q, stage_d;
  logic [4*WORD_W-1:0]      block_out_q, block_out_d;
  logic                     block_valid_q, block_valid_d;
  logic                     busy_q, busy_d;
  logic [15:0]              block_count_q, block_count_d;
  logic [4*WORD_W-1:0]      assembled;

  // Word 3 comes straight from the selector so the whole block lands in one update.
  always_comb begin
    assembled = '0;
    for (int i = 0; i < 4; i++) begin
      int pos;
      logic [WORD_W-1:0] word;
      pos  = MSB_FIRST ? (3 - i) : i;
      word = (i == 3) ? mux_result : stage_q[i];
      assembled[pos*WORD_W +: WORD_W] = word;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mux_select_d  = mux_select_q;
    stage_d       = stage_q;
    block_out_d   = block_out_q;
    block_valid_d = block_valid_q;
    block_count_d = block_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = GATHER;
          idx_d        = 2'd0;
          mux_select_d = 2'd0;
        end
      end
      GATHER: begin
        if (idx_q == 2'd3) begin
          block_out_d   = assembled;
          block_valid_d = 1'b1;
          state_d       = HOLD;
          idx_d         = 2'd0;
          mux_select_d  = 2'd0;
        end else begin
          if (idx_q == 2'd0) stage_d[0] = mux_result;
          if (idx_q == 2'd1) stage_d[1] = mux_result;
          if (idx_q == 2'd2) stage_d[2] = mux_result;
          idx_d        = idx_q + 2'd1;
          mux_select_d = idx_q + 2'd1;
        end
      end
      HOLD: begin
        if (block_ready) begin
          block_valid_d = 1'b0;
          block_count_d = block_count_q + 16'd1;
          idx_d         = 2'd0;
          mux_select_d  = 2'd0;
          state_d       = start ? GATHER : IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        idx_d        = 2'd0;
        mux_select_d = 2'd0;
      end
    endcase

    busy_d = (state_d == GATHER) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      mux_select_q  <= 2'd0;
      stage_q       <= '0;
      block_out_q   <= '0;
      block_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      block_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mux_select_q  <= mux_select_d;
      stage_q       <= stage_d;
      block_out_q   <= block_out_d;
      block_valid_q <= block_valid_d;
      busy_q        <= busy_d;
      block_count_q <= block_count_d;
    end
  end

  assign mux_select  = mux_select_q;
  assign block_out   = block_out_q;
  assign block_valid = block_valid_q;
  assign busy        = busy_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_word_block_packer.sv
// Directed bench for word_block_packer: LSB-first and MSB-first instances share stimulus.
module tb_word_block_packer;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           ready;
  logic [1:0]     sel, sel_m;
  logic [W-1:0]   res, res_m;
  logic [4*W-1:0] blk, blk_m;
  logic           vld, vld_m, bsy, bsy_m;
  logic [15:0]    cnt, cnt_m;
  logic [W-1:0]   wd [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign res   = wd[sel];
  assign res_m = wd[sel_m];

  word_block_packer #(.WORD_W(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_select(sel), .mux_result(res),
    .block_out(blk), .block_valid(vld), .block_ready(ready), .busy(bsy), .block_count(cnt)
  );

  word_block_packer #(.WORD_W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_select(sel_m), .mux_result(res_m),
    .block_out(blk_m), .block_valid(vld_m), .block_ready(ready), .busy(bsy_m), .block_count(cnt_m)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d;
  endtask

  // Start a block from IDLE and run until valid; checks the select walk and valid timing.
  task automatic gather_block(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " sel0"}, sel, 2'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check({tag, " sel step"}, sel, k[1:0]);
      check({tag, " vld low"}, vld, 1'b0);
    end
    tick();
    check({tag, " vld rise"}, vld, 1'b1);
    check({tag, " sel back0"}, sel, 2'd0);
  endtask

  typedef struct {
    logic        st;
    logic        rdy;
    logic [1:0]  sel;
    logic        vld;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [4*W-1:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    tbl[0] = '{st: 1'b1, rdy: 1'b1, sel: 2'd0, vld: 1'b0, bsy: 1'b1, cnt: 16'd0};
    tbl[1] = '{st: 1'b0, rdy: 1'b1, sel: 2'd1, vld: 1'b0, bsy: 1'b1, cnt: 16'd0};
    tbl[2] = '{st: 1'b0, rdy: 1'b1, sel: 2'd2, vld: 1'b0, bsy: 1'b1, cnt: 16'd0};
    tbl[3] = '{st: 1'b0, rdy: 1'b1, sel: 2'd3, vld: 1'b0, bsy: 1'b1, cnt: 16'd0};
    tbl[4] = '{st: 1'b0, rdy: 1'b0, sel: 2'd0, vld: 1'b1, bsy: 1'b1, cnt: 16'd0};
    tbl[5] = '{st: 1'b0, rdy: 1'b1, sel: 2'd0, vld: 1'b0, bsy: 1'b0, cnt: 16'd1};

    tick();
    tick();
    check("rst sel", sel, 2'd0);
    check("rst blk", blk, '0);
    check("rst vld", vld, 1'b0);
    check("rst busy", bsy, 1'b0);
    check("rst cnt", cnt, 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle no start busy", bsy, 1'b0);

    // Basic block; ready is ignored outside HOLD.
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].st;
      ready = tbl[i].rdy;
      tick();
      check("tbl sel", sel, tbl[i].sel);
      check("tbl vld", vld, tbl[i].vld);
      check("tbl busy", bsy, tbl[i].bsy);
      check("tbl cnt", cnt, tbl[i].cnt);
      if (i < 4) check("tbl blk unchanged", blk, '0);
      if (i == 4) begin
        check("basic blk lsb", blk, 128'h44444444_33333333_22222222_11111111);
        check("basic blk msb", blk_m, 128'h11111111_22222222_33333333_44444444);
        check("msb vld", vld_m, 1'b1);
      end
    end
    check("blk kept after handoff", blk, 128'h44444444_33333333_22222222_11111111);
    check("msb cnt", cnt_m, 16'd1);

    // Backpressure with start pulses ignored in HOLD.
    ready = 1'b0;
    set_words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    gather_block("bp");
    held = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    check("bp blk", blk, held);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      tick();
      check("bp vld stable", vld, 1'b1);
      check("bp blk stable", blk, held);
      check("bp sel", sel, 2'd0);
      check("bp cnt", cnt, 16'd1);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    check("bp vld fall", vld, 1'b0);
    check("bp cnt inc", cnt, 16'd2);
    check("bp idle", bsy, 1'b0);

    // Back-to-back: start with ready in HOLD goes straight to GATHER.
    ready = 1'b0;
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    gather_block("b2b1");
    set_words(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    check("b2b vld fall", vld, 1'b0);
    check("b2b busy", bsy, 1'b1);
    check("b2b sel", sel, 2'd0);
    check("b2b cnt", cnt, 16'd3);
    check("b2b blk held", blk, 128'h44444444_33333333_22222222_11111111);
    for (int i = 0; i < 3; i++) tick();
    check("b2b not yet", vld, 1'b0);
    tick();
    check("b2b vld2", vld, 1'b1);
    check("b2b blk2", blk, 128'h88888888_77777777_66666666_55555555);
    ready = 1'b1;
    tick();
    check("b2b cnt2", cnt, 16'd4);

    // Reset after word 1 captured.
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid sel2", sel, 2'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid rst sel", sel, 2'd0);
    check("mid rst blk", blk, '0);
    check("mid rst vld", vld, 1'b0);
    check("mid rst busy", bsy, 1'b0);
    check("mid rst cnt", cnt, 16'd0);
    tick();
    check("mid stays idle", bsy, 1'b0);
    set_words(32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF);
    gather_block("fresh");
    check("fresh blk", blk, 128'h89ABCDEF_01234567_CAFEF00D_DEADBEEF);
    ready = 1'b1;
    tick();
    check("fresh cnt", cnt, 16'd1);

    // Wrap of block_count.
    ready = 1'b0;
    force dut.block_count_q = 16'hFFFF;
    tick();
    release dut.block_count_q;
    tick();
    check("wrap preload", cnt, 16'hFFFF);
    gather_block("wrap");
    ready = 1'b1;
    tick();
    check("wrap cnt", cnt, 16'h0000);
    check("wrap vld", vld, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
